rega_status_encoder: RTL
========================

# rega_status_encoder

Sequential status encoder for the irrigation controller: samples the raw field sensors (soil humidity, tank level, manual request), synchronises and debounces them, and priority-encodes the system state into the 4-bit status code `C[3:0]`. `C[3:0]` is consumed by the seven-segment display decoder. A minimum dwell time keeps the display from flickering between states, and a change strobe marks each code update.

## Interface
- `DEB_CYCLES`, default 4: consecutive synchronised cycles an input must differ from its stable value before the stable value flips (≥2).
- `DWELL_CYCLES`, default 8: minimum cycles a non-error code is held before it may change (≥1).
- `CLK` in, 1 bit: single clock, all state rising-edge.
- `RESET` in, 1 bit: asynchronous, active-high reset.
- `H` in, 1 bit: soil humidity sensor. 1 = wet, 0 = dry. Asynchronous to `CLK`.
- `T_LOW` in, 1 bit: tank low-level probe. 1 = water above the low mark.
- `T_HIGH` in, 1 bit: tank high-level probe. 1 = water above the high mark.
- `MAN` in, 1 bit: manual irrigation request switch.
- `C` out, 4 bits: registered status code.
- `C_VALID` out, 1 bit: `C` holds a debounced code.
- `CHG` out, 1 bit: one-cycle pulse on the cycle `C` takes a new value.

## Operation
- **Input path.** Each input passes through a 2-FF synchroniser, then a debouncer with a counter of width clog2(DEB_CYCLES+1).
  - The counter clears whenever the synchronised input equals the stable value.
  - The counter increments while the two differ.
  - When the counter reaches DEB_CYCLES, the stable value flips and the counter clears.
- **Candidate code.** Combinational priority encode of the stable values, highest priority first:
  - ERR = 4'h1: T_HIGH=1 with T_LOW=0 (inconsistent probes).
  - EMPTY = 4'h4: T_LOW=0.
  - MANUAL = 4'h6: MAN=1.
  - WATER = 4'h2: H=0 (dry soil, tank usable).
  - IDLE = 4'h0: otherwise.
- **FSM states.** INIT, HOLD, READY.
  - INIT: the init counter runs DEB_CYCLES+2 cycles after reset release. On expiry, load `C`, set `C_VALID`=1, pulse `CHG`, load the dwell counter, go to HOLD.
  - HOLD: the dwell counter decrements. At 0, go to READY. If the candidate is ERR and `C`≠ERR, load ERR immediately, pulse `CHG`, and restart dwell (error preempts dwell).
  - READY: if candidate ≠ `C`, load the candidate, pulse `CHG`, load dwell with DWELL_CYCLES-1, go to HOLD. Otherwise stay.
- A candidate that changes and reverts during HOLD is never displayed. Only the value present on the READY cycle counts.
- **Reset values.** `C`=4'h0, `C_VALID`=0, `CHG`=0, all synchroniser and stable bits 0, counters 0, state INIT.
- **Reset mid-operation.** All outputs return to reset values asynchronously. The full INIT sequence repeats after release.

## Timing
- An input change sampled at edge k:
  - synchroniser output at edge k+1;
  - stable value flips at edge k+1+DEB_CYCLES;
  - `C`/`CHG` update at edge k+2+DEB_CYCLES if the FSM is in READY (6 cycles at defaults).
- A glitch shorter than DEB_CYCLES synchronised cycles never reaches the stable value.
- After a non-ERR update, the next update is ≥DWELL_CYCLES cycles later. ERR updates are not subject to dwell.
- `CHG` is high for exactly one cycle, coincident with the new `C`. It never asserts while `C_VALID`=0.
- A new code that equals the current code does not pulse `CHG`.

## Structure
- A shared package `rega_pkg` holds:
  - the code constants CODE_IDLE, CODE_WATER, CODE_EMPTY, CODE_MANUAL, CODE_ERR;
  - the FSM state typedef.
- The display decoder uses the same constants.
- Sub-module `rega_debounce`: the synchroniser plus debouncer, one instance per input, parameterised by DEB_CYCLES.
- The top level contains the priority encoder, FSM, dwell counter and init counter.

## Test plan
- **Reset and init.** RESET high with H=1, T_LOW=1, T_HIGH=0, MAN=0, then released → `C`=0, `C_VALID`=0 for DEB_CYCLES+2 cycles, then `C`=4'h0, `C_VALID`=1, one `CHG` pulse.
- **Debounce.** From IDLE, pulse H=0 for 2 cycles → no change. Hold H=0 → `C`=4'h2 exactly 6 cycles after the sampling edge, single `CHG`.
- **Priority.** H=0, MAN=1, T_LOW=0 applied together → `C`=4'h4. Then T_LOW=1 → after dwell, `C`=4'h6.
- **Dwell.** Set H=0; one cycle after `C`=4'h2, set H=1 → `C` returns to 4'h0 no earlier than 8 cycles after the first update.
- **Error preemption.** During HOLD with `C`=4'h2, drive T_HIGH=1, T_LOW=0 → `C`=4'h1 on the debounce-completion edge, regardless of remaining dwell.
- **Mid-operation reset.** Assert RESET mid-HOLD → `C`=0, `C_VALID`=0, `CHG`=0 immediately. After release, the INIT sequence repeats.

Source files
------------

// File: rtl/rega_pkg.sv
// Shared constants and types for the irrigation status encoder and the display decoder.
// Also holds the status priority encoder used by the top level.
package rega_pkg;

    localparam logic [3:0] CODE_IDLE   = 4'h0;
    localparam logic [3:0] CODE_ERR    = 4'h1;
    localparam logic [3:0] CODE_WATER  = 4'h2;
    localparam logic [3:0] CODE_EMPTY  = 4'h4;
    localparam logic [3:0] CODE_MANUAL = 4'h6;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_HOLD,
        ST_READY
    } state_e;

    // Highest priority first: inconsistent probes, empty tank, manual, dry soil.
    function automatic logic [3:0] encodeStatus(input logic h, input logic tLow,
                                                input logic tHigh, input logic man);
        logic [3:0] code;
        if (tHigh && !tLow) begin
            code = CODE_ERR;
        end else if (!tLow) begin
            code = CODE_EMPTY;
        end else if (man) begin
            code = CODE_MANUAL;
        end else if (!h) begin
            code = CODE_WATER;
        end else begin
            code = CODE_IDLE;
        end
        return code;
    endfunction

endpackage

// File: rtl/rega_debounce.sv
// Two-flop synchroniser followed by a debouncer for one asynchronous field sensor.
// The stable value only flips after DEB_CYCLES consecutive differing synchronised samples.
module rega_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cntInc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= raw_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any agreement with the stable value restarts the run of differing samples.
    always_comb begin
        cntInc   = cnt_q + 1'b1;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q != stable_q) begin
            if (cntInc == CNT_W'(DEB_CYCLES)) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cntInc;
            end
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/rega_status_encoder.sv
// Irrigation status encoder: debounced sensors, priority encode, and a dwell-limited
// registered status code with a change strobe for the seven-segment decoder.
module rega_status_encoder
    import rega_pkg::*;
#(
    parameter int DEB_CYCLES   = 4,
    parameter int DWELL_CYCLES = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       H,
    input  logic       T_LOW,
    input  logic       T_HIGH,
    input  logic       MAN,
    output logic [3:0] C,
    output logic       C_VALID,
    output logic       CHG
);

    localparam int INIT_W  = $clog2(DEB_CYCLES + 3);
    localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);

    localparam logic [INIT_W-1:0]  INIT_LAST  = INIT_W'(DEB_CYCLES + 2);
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

    logic hStable;
    logic tLowStable;
    logic tHighStable;
    logic manStable;
    logic [3:0] candidate;

    state_e              state_q, state_d;
    logic [3:0]          code_q, code_d;
    logic                valid_q, valid_d;
    logic                chg_q, chg_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [INIT_W-1:0]   initCnt_q, initCnt_d;

    rega_debounce #(.DEB_CYCLES(DEB_CYCLES)) uDebH (
        .clk(CLK), .rst(RESET), .raw_i(H), .stable_o(hStable)
    );

    rega_debounce #(.DEB_CYCLES(DEB_CYCLES)) uDebTLow (
        .clk(CLK), .rst(RESET), .raw_i(T_LOW), .stable_o(tLowStable)
    );

    rega_debounce #(.DEB_CYCLES(DEB_CYCLES)) uDebTHigh (
        .clk(CLK), .rst(RESET), .raw_i(T_HIGH), .stable_o(tHighStable)
    );

    rega_debounce #(.DEB_CYCLES(DEB_CYCLES)) uDebMan (
        .clk(CLK), .rst(RESET), .raw_i(MAN), .stable_o(manStable)
    );

    assign candidate = encodeStatus(hStable, tLowStable, tHighStable, manStable);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_INIT;
            code_q    <= CODE_IDLE;
            valid_q   <= 1'b0;
            chg_q     <= 1'b0;
            dwell_q   <= '0;
            initCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            chg_q     <= chg_d;
            dwell_q   <= dwell_d;
            initCnt_q <= initCnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        valid_d   = valid_q;
        chg_d     = 1'b0;
        dwell_d   = dwell_q;
        initCnt_d = initCnt_q;
        case (state_q)
            // Wait for the debouncers to settle before showing anything.
            ST_INIT: begin
                if (initCnt_q == INIT_LAST) begin
                    code_d  = candidate;
                    valid_d = 1'b1;
                    chg_d   = 1'b1;
                    dwell_d = DWELL_LOAD;
                    state_d = ST_HOLD;
                end else begin
                    initCnt_d = initCnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (candidate == CODE_ERR && code_q != CODE_ERR) begin
                    code_d  = CODE_ERR;
                    chg_d   = 1'b1;
                    dwell_d = DWELL_LOAD;
                end else if (dwell_q == '0) begin
                    state_d = ST_READY;
                end else begin
                    dwell_d = dwell_q - 1'b1;
                end
            end
            ST_READY: begin
                if (candidate != code_q) begin
                    code_d  = candidate;
                    chg_d   = 1'b1;
                    dwell_d = DWELL_LOAD;
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign C       = code_q;
    assign C_VALID = valid_q;
    assign CHG     = chg_q;

endmodule
